// File: rtl/oflow_core_fsm_registration_if.sv
// Handshake bundle between the FE/registration control FSM and its neighbours
// (FE FSM inputs, shared registration datapath start/ack, frame status).
interface oflow_core_fsm_registration_if #(
    parameter int PE_NUM          = 24,
    parameter int SET_LEN         = 8,
    parameter int REMAIN_BBOX_LEN = 5
);
    localparam int IDX_W = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;

    logic                       start_pe;
    logic [SET_LEN-1:0]         num_of_sets;
    logic [REMAIN_BBOX_LEN-1:0] counter_of_remain_bboxes;
    logic                       done_fe;
    logic                       reg_ack;
    logic [PE_NUM-1:0]          start_reg_i;
    logic [IDX_W-1:0]           reg_pe_idx;
    logic [SET_LEN-1:0]         counter_set_reg;
    logic                       done_registration;
    logic                       done_frame;

    // Environment side: FE FSM, frame control and registration datapath.
    modport master (
        output start_pe, num_of_sets, counter_of_remain_bboxes, done_fe, reg_ack,
        input  start_reg_i, reg_pe_idx, counter_set_reg, done_registration, done_frame
    );

    // Registration control FSM side.
    modport slave (
        input  start_pe, num_of_sets, counter_of_remain_bboxes, done_fe, reg_ack,
        output start_reg_i, reg_pe_idx, counter_set_reg, done_registration, done_frame
    );
endinterface

// File: rtl/oflow_core_fsm_registration.sv
// Registration control FSM: after the FE stage finishes a set, walks the active PEs
// one at a time through the shared registration datapath and reports set/frame completion.
module oflow_core_fsm_registration #(
    parameter int PE_NUM          = 24,
    parameter int SET_LEN         = 8,
    parameter int REMAIN_BBOX_LEN = 5
) (
    input  logic                           clk,
    input  logic                           reset_N,
    oflow_core_fsm_registration_if.slave   bus
);
    localparam int IDX_W = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
    localparam logic [PE_NUM-1:0]          ONE_HOT0   = PE_NUM'(1);
    localparam logic [SET_LEN-1:0]         SET_ONE    = SET_LEN'(1);
    localparam logic [IDX_W-1:0]           IDX_ONE    = IDX_W'(1);
    localparam logic [REMAIN_BBOX_LEN-1:0] FULL_SET   = REMAIN_BBOX_LEN'(PE_NUM);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FE,
        REG,
        WAIT_ACK,
        SET_DONE
    } state_t;

    state_t                     state;
    logic [REMAIN_BBOX_LEN-1:0] active_cnt;
    logic [PE_NUM-1:0]          start_reg_i;
    logic [IDX_W-1:0]           reg_pe_idx;
    logic [SET_LEN-1:0]         counter_set_reg;
    logic                       done_registration;
    logic                       done_frame;

    logic                       last_set;
    logic                       last_pe;
    logic [REMAIN_BBOX_LEN-1:0] set_size;

    assign last_set = (counter_set_reg == (bus.num_of_sets - SET_ONE));
    assign last_pe  = ((32'(reg_pe_idx) + 32'd1) == 32'(active_cnt));
    // A zero remainder means the final set is completely populated.
    assign set_size = (last_set && (bus.counter_of_remain_bboxes != '0))
                      ? bus.counter_of_remain_bboxes : FULL_SET;

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state             <= IDLE;
            active_cnt        <= FULL_SET;
            start_reg_i       <= '0;
            reg_pe_idx        <= '0;
            counter_set_reg   <= '0;
            done_registration <= 1'b0;
            done_frame        <= 1'b0;
        end else begin
            start_reg_i <= '0;
            done_frame  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_pe) begin
                        if (bus.num_of_sets != '0) begin
                            state             <= WAIT_FE;
                            counter_set_reg   <= '0;
                            done_registration <= 1'b0;
                        end else begin
                            done_frame <= 1'b1;
                        end
                    end
                end
                WAIT_FE: begin
                    if (bus.done_fe) begin
                        state             <= REG;
                        active_cnt        <= set_size;
                        reg_pe_idx        <= '0;
                        done_registration <= 1'b0;
                        start_reg_i       <= ONE_HOT0;
                    end
                end
                REG: begin
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (bus.reg_ack) begin
                        if (last_pe) begin
                            state <= SET_DONE;
                        end else begin
                            state       <= REG;
                            reg_pe_idx  <= reg_pe_idx + IDX_ONE;
                            start_reg_i <= ONE_HOT0 << (reg_pe_idx + IDX_ONE);
                        end
                    end
                end
                SET_DONE: begin
                    done_registration <= 1'b1;
                    if (last_set) begin
                        state      <= IDLE;
                        done_frame <= 1'b1;
                    end else begin
                        state           <= WAIT_FE;
                        counter_set_reg <= counter_set_reg + SET_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.start_reg_i       = start_reg_i;
    assign bus.reg_pe_idx        = reg_pe_idx;
    assign bus.counter_set_reg   = counter_set_reg;
    assign bus.done_registration = done_registration;
    assign bus.done_frame        = done_frame;
endmodule

// File: tb/tb_oflow_core_fsm_registration.sv
// Bench for oflow_core_fsm_registration: drives frames with random gaps, ack delays and
// ignored-input noise, and predicts every output from the set/PE walk arithmetic.
module tb_oflow_core_fsm_registration;
    localparam int PE_NUM  = 24;
    localparam int SET_LEN = 8;
    localparam int RB_LEN  = 5;

    logic clk = 1'b0;
    logic reset_N;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    oflow_core_fsm_registration_if #(
        .PE_NUM(PE_NUM), .SET_LEN(SET_LEN), .REMAIN_BBOX_LEN(RB_LEN)
    ) bus ();

    oflow_core_fsm_registration #(
        .PE_NUM(PE_NUM), .SET_LEN(SET_LEN), .REMAIN_BBOX_LEN(RB_LEN)
    ) dut (
        .clk     (clk),
        .reset_N (reset_N),
        .bus     (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_start"}, 32'(bus.start_reg_i), 0);
        check_val({tag, "_idx"}, 32'(bus.reg_pe_idx), 0);
        check_val({tag, "_set"}, 32'(bus.counter_set_reg), 0);
        check_val({tag, "_dreg"}, 32'(bus.done_registration), 0);
        check_val({tag, "_dframe"}, 32'(bus.done_frame), 0);
    endtask

    // Called in an IDLE cycle; returns in the IDLE cycle after done_frame has dropped.
    task automatic run_frame(input int nsets, input int remain, input int max_gap,
                             input int min_dly, input int max_dly, input bit noise,
                             input bit hold_fe);
        int n;
        int g;
        int d;
        bus.num_of_sets              = SET_LEN'(nsets);
        bus.counter_of_remain_bboxes = RB_LEN'(remain);
        bus.start_pe = 1'b1;
        bus.done_fe  = 1'b0;
        bus.reg_ack  = 1'b0;
        step();
        bus.start_pe = 1'b0;
        check_val("frame_start_dreg", 32'(bus.done_registration), 0);
        check_val("frame_start_set", 32'(bus.counter_set_reg), 0);
        for (int s = 0; s < nsets; s++) begin
            n = (s == nsets - 1 && remain != 0) ? remain : PE_NUM;
            g = hold_fe ? 0 : $urandom_range(max_gap, 0);
            for (int i = 0; i < g; i++) begin
                bus.done_fe = 1'b0;
                bus.reg_ack = noise;
                step();
                check_val("gap_start", 32'(bus.start_reg_i), 0);
                check_val("gap_dreg", 32'(bus.done_registration), (s > 0) ? 1 : 0);
                check_val("gap_set", 32'(bus.counter_set_reg), s);
            end
            bus.done_fe = 1'b1;
            bus.reg_ack = noise;
            step();
            for (int k = 0; k < n; k++) begin
                check_val("start_onehot", 32'(bus.start_reg_i), 32'd1 << k);
                check_val("pe_idx", 32'(bus.reg_pe_idx), k);
                check_val("set_idx", 32'(bus.counter_set_reg), s);
                check_val("dreg_low", 32'(bus.done_registration), 0);
                bus.done_fe  = noise ? 1'($urandom_range(1, 0)) : 1'b0;
                bus.start_pe = noise ? 1'($urandom_range(1, 0)) : 1'b0;
                bus.reg_ack  = noise;
                step();
                bus.start_pe = 1'b0;
                d = $urandom_range(max_dly, min_dly);
                for (int j = 0; j < d; j++) begin
                    bus.reg_ack = 1'b0;
                    step();
                    check_val("ack_wait_start", 32'(bus.start_reg_i), 0);
                    check_val("ack_wait_idx", 32'(bus.reg_pe_idx), k);
                end
                bus.reg_ack = 1'b1;
                step();
                bus.reg_ack = 1'b0;
            end
            bus.done_fe = hold_fe;
            check_val("setdone_start", 32'(bus.start_reg_i), 0);
            check_val("setdone_dreg", 32'(bus.done_registration), 0);
            check_val("setdone_dframe", 32'(bus.done_frame), 0);
            step();
            check_val("dreg_high", 32'(bus.done_registration), 1);
            check_val("done_frame", 32'(bus.done_frame), (s == nsets - 1) ? 1 : 0);
            check_val("set_next", 32'(bus.counter_set_reg), (s == nsets - 1) ? s : s + 1);
        end
        bus.done_fe  = 1'b0;
        bus.start_pe = 1'b0;
        step();
        check_val("done_frame_drop", 32'(bus.done_frame), 0);
        check_val("dreg_hold", 32'(bus.done_registration), 1);
        check_val("idle_start", 32'(bus.start_reg_i), 0);
    endtask

    initial begin
        reset_N = 1'b0;
        bus.start_pe = 1'b0;
        bus.num_of_sets = '0;
        bus.counter_of_remain_bboxes = '0;
        bus.done_fe = 1'b0;
        bus.reg_ack = 1'b0;
        step();
        step();
        check_all_zero("reset");
        reset_N = 1'b1;
        step();

        // Single short set, ack one cycle after each start.
        run_frame(1, 3, 2, 0, 0, 1'b0, 1'b0);
        // Two full sets, immediate acks.
        run_frame(2, 0, 1, 0, 0, 1'b0, 1'b0);
        // Acks five cycles after start with spurious acks in gaps and REG.
        run_frame(1, 4, 3, 4, 4, 1'b1, 1'b0);

        // Empty frame.
        bus.num_of_sets = '0;
        bus.start_pe = 1'b1;
        step();
        bus.start_pe = 1'b0;
        check_val("empty_dframe", 32'(bus.done_frame), 1);
        check_val("empty_start", 32'(bus.start_reg_i), 0);
        step();
        check_val("empty_dframe_drop", 32'(bus.done_frame), 0);
        check_val("empty_start2", 32'(bus.start_reg_i), 0);

        // Asynchronous reset while waiting for the ack of PE 7.
        bus.num_of_sets = SET_LEN'(2);
        bus.counter_of_remain_bboxes = '0;
        bus.start_pe = 1'b1;
        step();
        bus.start_pe = 1'b0;
        bus.done_fe = 1'b1;
        step();
        bus.done_fe = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k < 7) begin
                bus.reg_ack = 1'b1;
                step();
                bus.reg_ack = 1'b0;
            end
        end
        check_val("pre_rst_idx", 32'(bus.reg_pe_idx), 7);
        #2;
        reset_N = 1'b0;
        #1;
        check_all_zero("async_rst");
        step();
        step();
        reset_N = 1'b1;
        step();
        run_frame(1, 2, 1, 0, 1, 1'b0, 1'b0);

        // done_fe held high across set boundaries.
        run_frame(3, 2, 0, 0, 1, 1'b0, 1'b1);

        for (int f = 0; f < 6; f++) begin
            run_frame($urandom_range(3, 1), $urandom_range(PE_NUM, 0), 3, 0, 3, 1'b1,
                      1'($urandom_range(1, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
